mem_port_arbiter: RTL

Arbitrates the single-port 1024x32 unified instruction/data memory between three requesters: the program loader (boot-time image load), the MEM stage (LW/SW) and the IF stage (instruction fetch). Uses fixed priority with a starvation guard for IF. Sequences each granted access through issue, fixed-latency wait and response. One access is in flight at a time, and every access completes with a one-cycle ack to its requester.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared single-port instruction/data memory: loader > MEM stage > IF,
// with IF promoted over the MEM stage after STARVE_LIMIT consecutive lost arbitrations.
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        gnt_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] ID_LD   = 2'b00;
  localparam logic [1:0] ID_DM   = 2'b01;
  localparam logic [1:0] ID_IF   = 2'b10;
  localparam logic [1:0] ID_NONE = 2'b11;
  localparam logic [2:0] LAT     = 3'(MEM_LAT);
  localparam logic [3:0] SLIM    = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [1:0]        id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t     state_q, state_d;
  acc_t       win, cur_q;
  logic       any_req, if_first;
  logic [2:0] wcnt_q, wcnt_d;
  logic [3:0] starve_q, starve_d;

  assign any_req  = ld_req | dm_req | if_req;
  assign if_first = (starve_q == SLIM);

  // Winner of the current IDLE arbitration; only consumed while IDLE.
  always_comb begin
    win       = '0;
    win.id    = ID_NONE;
    if (ld_req) begin
      win.id    = ID_LD;
      win.we    = ld_we;
      win.addr  = ld_addr;
      win.wdata = ld_wdata;
    end else if (dm_req && !(if_req && if_first)) begin
      win.id    = ID_DM;
      win.we    = dm_we;
      win.addr  = dm_addr;
      win.wdata = dm_wdata;
    end else if (if_req) begin
      win.id    = ID_IF;
      win.addr  = if_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!if_req || win.id == ID_IF) starve_d = '0;
      else if (starve_q != SLIM)      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: begin
        if (cur_q.we) state_d = RESP;
        else begin
          state_d = WAIT;
          wcnt_d  = LAT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      wcnt_q    <= '0;
      starve_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      starve_q <= starve_d;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      // Latching and strobing on the same edge keeps the memory bus registered.
      if (state_q == IDLE && any_req) begin
        cur_q     <= win;
        mem_en    <= 1'b1;
        mem_we    <= win.we;
        mem_addr  <= win.addr;
        mem_wdata <= win.wdata;
      end
      if (state_q == WAIT && wcnt_q == 3'd1) rdata <= mem_rdata;
    end
  end

  assign busy   = (state_q != IDLE);
  assign gnt_id = busy ? cur_q.id : ID_NONE;
  assign ld_ack = (state_q == RESP) && (cur_q.id == ID_LD);
  assign dm_ack = (state_q == RESP) && (cur_q.id == ID_DM);
  assign if_ack = (state_q == RESP) && (cur_q.id == ID_IF);
endmodule
